bb_halfduplex_ctrl: RTL and testbench
=====================================

Name: bb_halfduplex_ctrl

Overview:
- Sequences one bidirectional pad built from a BB primitive.
- Shares that pad between a write requester and a read requester. Each transfer is DATA_W bits, LSB first, one bit per clock.
- Inserts turnaround cycles, with the pad released, whenever the transfer direction changes.
- Drives BB.I and BB.T and samples BB.O. Sits between on-chip logic and a half-duplex single-wire peripheral.

Parameters:
- DATA_W, 8, bits per transfer (≥1).
- TA_CYCLES, 2, released cycles inserted on a direction change (≥0; 0 means no TURN state).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous and active-high.
- WR_VALID  in  1  write request.
- WR_READY  out  1  write accepted this cycle.
- WR_DATA  in  DATA_W  write word; sampled on the accept edge.
- RD_VALID  in  1  read request.
- RD_READY  out  1  read accepted this cycle.
- RD_DATA  out  DATA_W  last completed read word.
- RD_DONE  out  1  one-cycle pulse when RD_DATA is updated.
- BUSY  out  1  high in every state except IDLE.
- PAD_I  out  1  to BB.I.
- PAD_T  out  1  to BB.T; 1 = high-Z.
- PAD_O  in  1  from BB.O.

Behaviour:
- Reset: synchronous, and overrides everything, including mid-transfer. It gives:
  - state=IDLE, PAD_T=1, PAD_I=0, RD_DATA=0, RD_DONE=0, BUSY=0.
  - bit and turnaround counters = 0.
  - last_dir=READ, last_grant=READ.
  - A partial read is discarded and a partial write is abandoned.
- States: IDLE, TURN, WRITE, READ.
- Outputs by state:
  - PAD_T=0 only in WRITE; PAD_I=0 outside WRITE.
  - PAD_I and PAD_T are registered, with no combinational path from inputs.
- Acceptance (combinational, IDLE only, RST low):
  - WR_READY = WR_VALID & (!RD_VALID | last_grant==READ).
  - RD_READY = RD_VALID & (!WR_VALID | last_grant==WRITE).
  - Never both high in the same cycle.
  - READY depends on VALID; requesters must not wait for READY before asserting VALID.
- On an accept edge:
  - WR_DATA is latched into the shift register.
  - last_grant is updated.
  - If the new direction differs from last_dir and TA_CYCLES>0, go to TURN. Otherwise go straight to WRITE or READ.
  - last_dir is updated.
- TURN: lasts exactly TA_CYCLES cycles with PAD_T=1, then goes to the pending direction.
- WRITE:
  - Lasts DATA_W cycles; in cycle k, PAD_I = WR_DATA[k] (k=0 first).
  - Then returns to IDLE, where PAD_T=1 again and the pad is released immediately.
- READ:
  - Lasts DATA_W cycles, with PAD_O sampled at the rising edge that ends cycle k into shadow bit k.
  - The next cycle is IDLE: RD_DATA gets the shadow, RD_DONE=1 for that single cycle.
  - RD_DATA is held until the next read completes.
- Back-to-back:
  - A new accept may happen in the first IDLE cycle after a transfer, including the RD_DONE cycle.
  - Same-direction transfers incur no turnaround, so the minimum gap is one IDLE cycle.
- Latency (DATA_W=8, TA=2):
  - Write with turnaround accepted at edge 0: TURN in cycles 1–2, bits in cycles 3–10, IDLE in cycle 11.
  - Without turnaround: bits in cycles 1–8.
- Counters are sized clog2(max(DATA_W,TA_CYCLES)+1) and wrap never occurs. The TURN counter is unused when TA_CYCLES=0.
- A VALID dropped before acceptance is simply not served.
- After reset the first read needs no turnaround, because last_dir=READ. The first write does need turnaround.

Test Plan:
- Reset, then WR_VALID with WR_DATA=8'h96 → WR_READY at cycle 0; PAD_T=1 for cycles 1–2; PAD_T=0 and PAD_I=0,1,1,0,1,0,0,1 in cycles 3–10; PAD_T=1 and BUSY=0 at cycle 11.
- Two consecutive writes, 8'hFF then 8'h00 → second accepted in the first IDLE cycle; bits follow with no TURN cycles.
- Write 8'h01, then read while the bench drives PAD_O with the 8'hA5 bit pattern after release → PAD_T=1 immediately after the write; 2 TURN cycles; RD_DONE single pulse with RD_DATA=8'hA5, held thereafter.
- WR_VALID and RD_VALID both held high from reset → grants alternate W, R, W, R; a TURN is inserted before every transfer; READY signals are never simultaneous.
- RST asserted at WRITE bit 4 → next cycle PAD_T=1, PAD_I=0, BUSY=0; RD_DATA unchanged at 0; next write again gets a turnaround.
- TA_CYCLES=0 build: read then write → the write's bits start the cycle after accept; no cycle with PAD_T=0 overlaps READ.

Source files
------------

// File: rtl/bb_halfduplex_ctrl.sv
// Half-duplex controller for one BB bidirectional pad: arbitrates write/read requesters,
// shifts DATA_W bits LSB first and releases the pad for TA_CYCLES on direction changes.
module bb_halfduplex_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TA_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              RD_VALID,
    output logic              RD_READY,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_DONE,
    output logic              BUSY,
    output logic              PAD_I,
    output logic              PAD_T,
    input  logic              PAD_O
);

    localparam int unsigned CNT_MAX  = (DATA_W > TA_CYCLES) ? DATA_W : TA_CYCLES;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] TA_LAST  = CW'((TA_CYCLES > 0) ? (TA_CYCLES - 1) : 0);
    localparam bit   USE_TURN = (TA_CYCLES > 0);
    localparam logic DIR_RD   = 1'b0;
    localparam logic DIR_WR   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_bit_cnt;
    logic [CW-1:0]     r_ta_cnt;
    logic              r_last_dir;
    logic              r_last_grant;
    logic              r_pend_dir;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_done;
    logic              r_pad_i;
    logic              r_pad_t;
    logic              w_wr_ready;
    logic              w_rd_ready;
    logic [DATA_W-1:0] w_tx_src;
    logic [DATA_W-1:0] w_shadow_nxt;

    // Round-robin acceptance: on contention the direction not granted last time wins.
    assign w_wr_ready = (r_state == S_IDLE) && !RST && WR_VALID
                        && (!RD_VALID || (r_last_grant == DIR_RD));
    assign w_rd_ready = (r_state == S_IDLE) && !RST && RD_VALID
                        && (!WR_VALID || (r_last_grant == DIR_WR));

    assign WR_READY = w_wr_ready;
    assign RD_READY = w_rd_ready;
    assign RD_DATA  = r_rd_data;
    assign RD_DONE  = r_rd_done;
    assign BUSY     = (r_state != S_IDLE);
    assign PAD_I    = r_pad_i;
    assign PAD_T    = r_pad_t;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_wr_ready) begin
                    w_state_nxt = (USE_TURN && (r_last_dir != DIR_WR)) ? S_TURN : S_WRITE;
                end else if (w_rd_ready) begin
                    w_state_nxt = (USE_TURN && (r_last_dir != DIR_RD)) ? S_TURN : S_READ;
                end
            end
            S_TURN: begin
                if (r_ta_cnt == TA_LAST) begin
                    w_state_nxt = (r_pend_dir == DIR_WR) ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next transmit word comes straight from WR_DATA when a write starts without turnaround.
    always_comb begin
        w_tx_src     = (r_state == S_IDLE) ? WR_DATA : r_shift;
        w_shadow_nxt = r_shadow;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (r_bit_cnt == CW'(i)) begin
                w_shadow_nxt[i] = PAD_O;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_ta_cnt     <= '0;
            r_last_dir   <= DIR_RD;
            r_last_grant <= DIR_RD;
            r_pend_dir   <= DIR_RD;
            r_shift      <= '0;
            r_shadow     <= '0;
            r_rd_data    <= '0;
            r_rd_done    <= 1'b0;
            r_pad_i      <= 1'b0;
            r_pad_t      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_done <= 1'b0;
            r_pad_t   <= (w_state_nxt != S_WRITE);
            r_pad_i   <= (w_state_nxt == S_WRITE) ? w_tx_src[0] : 1'b0;
            if (w_state_nxt == S_WRITE) begin
                r_shift <= w_tx_src >> 1;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_ta_cnt  <= '0;
                    r_bit_cnt <= '0;
                    if (w_wr_ready) begin
                        r_last_grant <= DIR_WR;
                        r_last_dir   <= DIR_WR;
                        r_pend_dir   <= DIR_WR;
                        if (w_state_nxt == S_TURN) begin
                            r_shift <= WR_DATA;
                        end
                    end else if (w_rd_ready) begin
                        r_last_grant <= DIR_RD;
                        r_last_dir   <= DIR_RD;
                        r_pend_dir   <= DIR_RD;
                    end
                end
                S_TURN: begin
                    r_ta_cnt <= r_ta_cnt + CW'(1);
                end
                S_WRITE: begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
                S_READ: begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                    r_shadow  <= w_shadow_nxt;
                    if (r_bit_cnt == BIT_LAST) begin
                        r_rd_data <= w_shadow_nxt;
                        r_rd_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bb_halfduplex_ctrl.sv
// Directed bench: instance 0 uses TA_CYCLES=2, instance 1 uses TA_CYCLES=0; both share clock and reset.
module tb_bb_halfduplex_ctrl;

    logic            clk;
    logic            rst;
    logic [1:0]      wr_valid;
    logic [1:0]      wr_ready;
    logic [1:0][7:0] wr_data;
    logic [1:0]      rd_valid;
    logic [1:0]      rd_ready;
    logic [1:0][7:0] rd_data;
    logic [1:0]      rd_done;
    logic [1:0]      busy;
    logic [1:0]      pad_i;
    logic [1:0]      pad_t;
    logic [1:0]      pad_o;

    int total;
    int bad;

    bb_halfduplex_ctrl #(.DATA_W(8), .TA_CYCLES(2)) u_dut_ta2 (
        .CLK(clk), .RST(rst),
        .WR_VALID(wr_valid[0]), .WR_READY(wr_ready[0]), .WR_DATA(wr_data[0]),
        .RD_VALID(rd_valid[0]), .RD_READY(rd_ready[0]), .RD_DATA(rd_data[0]),
        .RD_DONE(rd_done[0]), .BUSY(busy[0]),
        .PAD_I(pad_i[0]), .PAD_T(pad_t[0]), .PAD_O(pad_o[0])
    );

    bb_halfduplex_ctrl #(.DATA_W(8), .TA_CYCLES(0)) u_dut_ta0 (
        .CLK(clk), .RST(rst),
        .WR_VALID(wr_valid[1]), .WR_READY(wr_ready[1]), .WR_DATA(wr_data[1]),
        .RD_VALID(rd_valid[1]), .RD_READY(rd_ready[1]), .RD_DATA(rd_data[1]),
        .RD_DONE(rd_done[1]), .BUSY(busy[1]),
        .PAD_I(pad_i[1]), .PAD_T(pad_t[1]), .PAD_O(pad_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle that follows the transfer.
    task automatic xfer(input int u, input bit is_wr, input logic [7:0] d, input int turns,
                        input bit hold, input string tag);
        if (is_wr) wr_data[u] = d;
        if (!hold) begin
            if (is_wr) wr_valid[u] = 1'b1;
            else       rd_valid[u] = 1'b1;
        end
        #1;
        check_eq({tag, "_wr_ready"}, 32'(wr_ready[u]), 32'(is_wr));
        check_eq({tag, "_rd_ready"}, 32'(rd_ready[u]), 32'(!is_wr));
        cyc();
        if (!hold) begin
            wr_valid[u] = 1'b0;
            rd_valid[u] = 1'b0;
        end
        for (int t = 0; t < turns; t++) begin
            pad_o[u] = 1'b0;
            #1;
            check_eq($sformatf("%s_turn%0d_pad_t", tag, t), 32'(pad_t[u]), 32'd1);
            check_eq($sformatf("%s_turn%0d_busy", tag, t), 32'(busy[u]), 32'd1);
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            if (!is_wr) pad_o[u] = d[k];
            #1;
            check_eq($sformatf("%s_bit%0d_pad_t", tag, k), 32'(pad_t[u]), is_wr ? 32'd0 : 32'd1);
            if (is_wr)
                check_eq($sformatf("%s_bit%0d_pad_i", tag, k), 32'(pad_i[u]), 32'(d[k]));
            else
                check_eq($sformatf("%s_bit%0d_pad_i", tag, k), 32'(pad_i[u]), 32'd0);
            cyc();
        end
        pad_o[u] = 1'b0;
        #1;
        check_eq({tag, "_end_pad_t"}, 32'(pad_t[u]), 32'd1);
        check_eq({tag, "_end_busy"}, 32'(busy[u]), 32'd0);
        check_eq({tag, "_end_rd_done"}, 32'(rd_done[u]), 32'(!is_wr));
        if (!is_wr) check_eq({tag, "_end_rd_data"}, 32'(rd_data[u]), 32'(d));
    endtask

    initial begin
        logic [7:0] wbits;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        wr_valid = '0;
        rd_valid = '0;
        wr_data  = '0;
        pad_o    = '0;

        // Reset state
        cyc();
        cyc();
        check_eq("rst_pad_t", 32'(pad_t[0]), 32'd1);
        check_eq("rst_pad_i", 32'(pad_i[0]), 32'd0);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data[0]), 32'd0);
        check_eq("rst_rd_done", 32'(rd_done[0]), 32'd0);
        rst = 1'b0;

        // First write after reset needs turnaround
        xfer(0, 1'b1, 8'h96, 2, 1'b0, "w96");
        // Same-direction back-to-back writes, no turnaround
        xfer(0, 1'b1, 8'hFF, 0, 1'b0, "wFF");
        xfer(0, 1'b1, 8'h00, 0, 1'b0, "w00");
        // Write then read with turnaround; read word held afterwards
        xfer(0, 1'b1, 8'h01, 0, 1'b0, "w01");
        xfer(0, 1'b0, 8'hA5, 2, 1'b0, "rA5");
        cyc();
        check_eq("rA5_hold_done", 32'(rd_done[0]), 32'd0);
        check_eq("rA5_hold_data", 32'(rd_data[0]), 32'hA5);
        cyc();
        check_eq("rA5_hold2_data", 32'(rd_data[0]), 32'hA5);

        // Both requesters held from reset: grants alternate, each with turnaround
        rst         = 1'b1;
        wr_valid[0] = 1'b1;
        rd_valid[0] = 1'b1;
        cyc();
        #1;
        check_eq("both_rst_wr_ready", 32'(wr_ready[0]), 32'd0);
        check_eq("both_rst_rd_ready", 32'(rd_ready[0]), 32'd0);
        check_eq("both_rst_rd_data", 32'(rd_data[0]), 32'd0);
        rst = 1'b0;
        xfer(0, 1'b1, 8'h3C, 2, 1'b1, "both_w1");
        xfer(0, 1'b0, 8'h5A, 2, 1'b1, "both_r1");
        xfer(0, 1'b1, 8'hC6, 2, 1'b1, "both_w2");
        xfer(0, 1'b0, 8'h17, 2, 1'b1, "both_r2");
        wr_valid[0] = 1'b0;
        rd_valid[0] = 1'b0;

        // Reset in the middle of a write
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check_eq("mid_pre_rd_data", 32'(rd_data[0]), 32'd0);
        wbits       = 8'hC3;
        wr_data[0]  = wbits;
        wr_valid[0] = 1'b1;
        #1;
        check_eq("mid_wr_ready", 32'(wr_ready[0]), 32'd1);
        cyc();
        wr_valid[0] = 1'b0;
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("mid_bit%0d_pad_i", k), 32'(pad_i[0]), 32'(wbits[k]));
            cyc();
        end
        #1;
        check_eq("mid_bit4_pad_t", 32'(pad_t[0]), 32'd0);
        rst = 1'b1;
        cyc();
        check_eq("mid_rst_pad_t", 32'(pad_t[0]), 32'd1);
        check_eq("mid_rst_pad_i", 32'(pad_i[0]), 32'd0);
        check_eq("mid_rst_busy", 32'(busy[0]), 32'd0);
        check_eq("mid_rst_rd_data", 32'(rd_data[0]), 32'd0);
        check_eq("mid_rst_rd_done", 32'(rd_done[0]), 32'd0);
        rst = 1'b0;
        xfer(0, 1'b1, 8'hE7, 2, 1'b0, "mid_wE7");

        // TA_CYCLES=0 instance: read then write, no TURN at all
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check_eq("ta0_rst_pad_t", 32'(pad_t[1]), 32'd1);
        xfer(1, 1'b0, 8'h69, 0, 1'b0, "ta0_r69");
        xfer(1, 1'b1, 8'h81, 0, 1'b0, "ta0_w81");
        cyc();
        check_eq("ta0_hold_data", 32'(rd_data[1]), 32'h69);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
